// File: rtl/dct_pkg.sv
// Shared defaults, element-width helper and bank status encoding for the DCT input buffer.
package dct_pkg;

    localparam int DCT_N_POINTS = 16;
    localparam int DCT_DATA_W   = 8;
    localparam int DCT_FRAC_W   = 8;

    // Two guard bits above the shifted sample keep the level-shifted form representable as signed.
    function automatic int out_w(input int data_w, input int frac_w);
        return data_w + frac_w + 2;
    endfunction

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/dct_buf_bank.sv
// One N_POINTS x OUT_W register bank: a beat writes element idx and its mirror N_POINTS-1-idx.
module dct_buf_bank
    import dct_pkg::*;
#(
    parameter int N_POINTS = DCT_N_POINTS,
    parameter int OUT_W    = out_w(DCT_DATA_W, DCT_FRAC_W),
    localparam int IW      = $clog2(N_POINTS)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [IW-1:0]             idx,
    input  logic [OUT_W-1:0]          d_lo,
    input  logic [OUT_W-1:0]          d_hi,
    output logic [N_POINTS*OUT_W-1:0] flat
);

    logic [N_POINTS-1:0][OUT_W-1:0] mem;
    logic [IW-1:0]                  idx_hi;

    assign idx_hi = IW'(N_POINTS - 1) - idx;

    // Contents are deliberately never reset; status bits upstream say when they are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx]    <= d_lo;
            mem[idx_hi] <= d_hi;
        end
    end

    assign flat = mem;

endmodule

// File: rtl/dct_input_pingpong_buffer.sv
// Ping-pong input stage for the DCT core: two lanes fill a block from both ends, core reads a flat vector.
// Optional macro DCT_LEVEL_SHIFT_EN selects JPEG-style level shift (pixel - 2**(DATA_W-1)) before scaling.
module dct_input_pingpong_buffer
    import dct_pkg::*;
#(
    parameter int  N_POINTS = DCT_N_POINTS,
    parameter int  DATA_W   = DCT_DATA_W,
    parameter int  FRAC_W   = DCT_FRAC_W,
    localparam int OUT_W    = out_w(DATA_W, FRAC_W)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_a,
    input  logic [DATA_W-1:0]         in_b,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic [N_POINTS*OUT_W-1:0] x_flat,
    output logic                      out_bank
);

    localparam int HALF = N_POINTS / 2;
    localparam int CW   = $clog2(HALF);
    localparam int IW   = CW + 1;

    logic [CW-1:0] cnt;
    logic          wr_bank;
    logic          rd_bank;
    bank_state_t   state [2];
    logic          accept;
    logic          ack;
    logic          last;
    logic [OUT_W-1:0] conv_a;
    logic [OUT_W-1:0] conv_b;
    logic [1:0][N_POINTS*OUT_W-1:0] bank_flat;

`ifdef DCT_LEVEL_SHIFT_EN
    // Subtracting the mid-code flips the MSB; the flipped bit is then the sign and is extended.
    assign conv_a = {{3{~in_a[DATA_W-1]}}, in_a[DATA_W-2:0], {FRAC_W{1'b0}}};
    assign conv_b = {{3{~in_b[DATA_W-1]}}, in_b[DATA_W-2:0], {FRAC_W{1'b0}}};
`else
    assign conv_a = {2'b00, in_a, {FRAC_W{1'b0}}};
    assign conv_b = {2'b00, in_b, {FRAC_W{1'b0}}};
`endif

    assign in_ready  = (state[wr_bank] != FULL);
    assign out_valid = (state[rd_bank] == FULL);
    assign out_bank  = rd_bank;
    assign accept    = in_valid && in_ready;
    assign ack       = out_valid && out_ack;
    assign last      = (cnt == CW'(HALF - 1));

    // accept and ack never target the same bank: a bank being written is not FULL, an acked one is.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            state[0] <= EMPTY;
            state[1] <= EMPTY;
        end else begin
            if (accept) begin
                cnt            <= last ? '0 : cnt + CW'(1);
                state[wr_bank] <= last ? FULL : FILLING;
                if (last)
                    wr_bank <= ~wr_bank;
            end
            if (ack) begin
                state[rd_bank] <= EMPTY;
                rd_bank        <= ~rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_buf_bank #(
            .N_POINTS(N_POINTS),
            .OUT_W   (OUT_W)
        ) u_bank (
            .clk (clk),
            .we  (accept && (wr_bank == 1'(b))),
            .idx (IW'(cnt)),
            .d_lo(conv_a),
            .d_hi(conv_b),
            .flat(bank_flat[b])
        );
    end

    assign x_flat = bank_flat[rd_bank];

endmodule

// File: tb/tb_dct_input_pingpong_buffer.sv
// Directed and randomized checks of the DCT ping-pong input buffer against a block-level scoreboard.
module tb_dct_input_pingpong_buffer;

    localparam int N  = 16;
    localparam int OW = 18;
    localparam int FW = N * OW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_a = '0;
    logic [7:0]    in_b = '0;
    logic          out_valid;
    logic          out_ack = 1'b0;
    logic [FW-1:0] x_flat;
    logic          out_bank;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dct_input_pingpong_buffer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ack  (out_ack),
        .x_flat   (x_flat),
        .out_bank (out_bank)
    );

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] cv(input int s);
`ifdef DCT_LEVEL_SHIFT_EN
        return OW'((s - 128) * 256);
`else
        return OW'(s * 256);
`endif
    endfunction

    // Expected block for beats in_a = a0+k, in_b = b0+k.
    function automatic logic [FW-1:0] blk(input int a0, input int b0);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N/2; k++) begin
            f[k*OW +: OW]       = cv((a0 + k) & 255);
            f[(N-1-k)*OW +: OW] = cv((b0 + k) & 255);
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b);
        logic rdy;
        int   guard;
        guard = 0;
        in_valid = 1'b1;
        in_a = 8'(a);
        in_b = 8'(b);
        do begin
            rdy = in_ready;
            tick();
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) chk("beat_timeout", rdy, 1);
        in_valid = 1'b0;
    endtask

    // Transaction-level scoreboard: blocks completed vs blocks handed over since last reset.
    typedef struct {
        logic [FW-1:0] data;
        logic          bank;
    } blk_t;

    blk_t          sb_q[$];
    logic [FW-1:0] part;
    int            part_k = 0;
    int            done_n = 0;
    int            pop_n  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb_q.delete();
                part_k = 0;
                done_n = 0;
            end else begin
                chk("sb_in_ready", in_ready, sb_q.size() < 2);
                chk("sb_out_valid", out_valid, sb_q.size() > 0);
                if (out_valid && out_ack && sb_q.size() > 0) begin
                    chk("sb_data", x_flat, sb_q[0].data);
                    chk("sb_bank", out_bank, sb_q[0].bank);
                    void'(sb_q.pop_front());
                    pop_n++;
                end
                if (in_valid && in_ready) begin
                    part[part_k*OW +: OW]       = cv(in_a);
                    part[(N-1-part_k)*OW +: OW] = cv(in_b);
                    if (part_k == N/2 - 1) begin
                        sb_q.push_back('{part, done_n[0]});
                        done_n++;
                        part_k = 0;
                    end else begin
                        part_k++;
                    end
                end
            end
        end
    end

    initial begin
        logic [FW-1:0] e;
        int pop0, beats, cyc;
        bit v;

        repeat (3) tick();
        reset_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bank", out_bank, 0);

        // Block 1: latency and hold without ack
        for (int k = 0; k < N/2; k++) begin
            beat(k, 100 + k);
            if (k == N/2 - 2) chk("b1_valid_early", out_valid, 0);
        end
        chk("b1_valid", out_valid, 1);
        chk("b1_x3", x_flat[3*OW +: OW], cv(3));
        chk("b1_x12", x_flat[12*OW +: OW], cv(103));
        e = blk(0, 100);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("b1_stable", x_flat, e);
        end

        // Block 2 fills the other bank, then input stalls
        for (int k = 0; k < N/2; k++) beat(20 + k, 40 + k);
        chk("b2_in_ready", in_ready, 0);
        chk("b2_out_bank", out_bank, 0);
        in_valid = 1'b1; in_a = 8'd60; in_b = 8'd70;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_ready", in_ready, 0);
            chk("stall_x", x_flat, e);
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("ack_valid", out_valid, 1);
        chk("ack_bank", out_bank, 1);
        chk("ack_x", x_flat, blk(20, 40));
        chk("ack_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) beat(60 + k, 70 + k);

        // Reset mid-block while block 2 is pending
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_bank", out_bank, 0);
        chk("mrst_ready", in_ready, 1);
        for (int k = 0; k < N/2; k++) begin
            beat(5 + k, 200 + k);
            if (k == 3) chk("mrst_no_early", out_valid, 0);
        end
        chk("mrst_blk_valid", out_valid, 1);
        chk("mrst_blk_bank", out_bank, 0);
        chk("mrst_blk_x", x_flat, blk(5, 200));

        // Last beat of next block and ack of pending block on the same edge
        for (int k = 0; k < N/2 - 1; k++) beat(30 + k, 130 + k);
        in_valid = 1'b1; in_a = 8'd37; in_b = 8'd137; out_ack = 1'b1;
        tick();
        in_valid = 1'b0; out_ack = 1'b0;
        chk("sim_valid", out_valid, 1);
        chk("sim_bank", out_bank, 1);
        chk("sim_x", x_flat, blk(30, 130));
        chk("sim_ready", in_ready, 1);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("sim_drained", out_valid, 0);

        // Continuous stream with immediate ack: one block per N/2 cycles, banks alternate
        out_ack = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_valid = 1'b1;
            in_a = 8'(c);
            in_b = 8'(c + 50);
            tick();
            v = ((c + 1) % (N/2) == 0);
            chk("cont_valid", out_valid, v);
            if (v) chk("cont_bank", out_bank, ((c + 1) / (N/2) - 1) % 2);
        end
        in_valid = 1'b0;
        out_ack = 1'b0;

        // Conversion boundaries
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < N/2; k++)
            beat((k == 0) ? 0 : (k == 1) ? 128 : (k == 2) ? 255 : k, k);
`ifdef DCT_LEVEL_SHIFT_EN
        chk("conv_0", x_flat[0*OW +: OW], 18'h38000);
        chk("conv_128", x_flat[1*OW +: OW], 18'h00000);
        chk("conv_255", x_flat[2*OW +: OW], 18'h07F00);
`else
        chk("conv_0", x_flat[0*OW +: OW], 18'h00000);
        chk("conv_128", x_flat[1*OW +: OW], 18'h08000);
        chk("conv_255", x_flat[2*OW +: OW], 18'h0FF00);
`endif
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("conv_acked", out_valid, 0);

        // Random valid/ack: 1000 blocks, scoreboard tracks order and contents
        pop0 = pop_n;
        beats = 0;
        cyc = 0;
        while (beats < 1000 * (N/2) && cyc < 60000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            out_ack = 1'($urandom_range(0, 1));
            v = in_valid && in_ready;
            tick();
            if (v) beats++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ack = 1'b1;
        repeat (4) tick();
        out_ack = 1'b0;
        chk("rand_blocks", pop_n - pop0, 1000);
        chk("rand_drain", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
